// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: latches a load/store request from the
// load/store unit, runs a req/ack handshake with a multi-cycle external
// memory, stalls the pipeline meanwhile and returns load data on memout.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] memaddress,
  input  logic [DATA_W-1:0] memin,
  input  logic              memread,
  input  logic              memwrite,
  output logic [DATA_W-1:0] memout,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  output logic              ext_we,
  output logic              ext_req,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  // Abort fires in the cycle the counter reaches this value with no ack,
  // so ext_req is held for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  logic [1:0]        state_q,     state_d;
  logic [DATA_W-1:0] memout_q,    memout_d;
  logic [ADDR_W-1:0] ext_addr_q,  ext_addr_d;
  logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
  logic              ext_we_q,    ext_we_d;
  logic              ext_req_q,   ext_req_d;
  logic              stall_q,     stall_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  // Next-state and output computation; done/err default low so they pulse.
  always_comb begin
    state_d     = state_q;
    memout_d    = memout_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_we_d    = ext_we_q;
    ext_req_d   = ext_req_q;
    stall_d     = stall_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memread && memwrite) begin
          // Conflicting strobes: refuse without touching external memory.
          err_d = 1'b1;
        end else if (memread || memwrite) begin
          ext_addr_d  = memaddress;
          ext_wdata_d = memin;
          ext_we_d    = memwrite;
          ext_req_d   = 1'b1;
          stall_d     = 1'b1;
          cnt_d       = '0;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (ext_ack) begin
          ext_req_d = 1'b0;
          stall_d   = 1'b0;
          done_d    = 1'b1;
          if (!ext_we_q) memout_d = ext_rdata;
          state_d   = S_FINISH;
        end else if (cnt_q == CNT_LAST) begin
          ext_req_d = 1'b0;
          stall_d   = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FINISH: begin
        // done is visible this cycle; strobes are deliberately not sampled.
        state_d = S_IDLE;
      end
      default: begin
        ext_req_d = 1'b0;
        stall_d   = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      memout_q    <= '0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_we_q    <= 1'b0;
      ext_req_q   <= 1'b0;
      stall_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      memout_q    <= memout_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_we_q    <= ext_we_d;
      ext_req_q   <= ext_req_d;
      stall_q     <= stall_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign memout    = memout_q;
  assign stall     = stall_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign ext_we    = ext_we_q;
  assign ext_req   = ext_req_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: the driver pushes the expected
// outcome of each request; a negedge monitor pops and compares.
module tb_dmem_access_ctrl;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] memaddress;
  logic [DW-1:0] memin;
  logic          memread, memwrite;
  logic [DW-1:0] memout;
  logic          stall, done, err;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_we, ext_req;
  logic [DW-1:0] ext_rdata;
  logic          ext_ack;

  dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .memaddress(memaddress), .memin(memin),
    .memread(memread), .memwrite(memwrite), .memout(memout), .stall(stall),
    .done(done), .err(err), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_we(ext_we), .ext_req(ext_req), .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    bit            accessed;
    int            run;
    logic [DW-1:0] mem;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    bit            we;
    logic [DW-1:0] wdata;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] drv_mem = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Issue one request; caller is 1 time unit after a rising edge. hold keeps
  // the strobe for an extra edge (first edge lands in FINISH); stray drives a
  // spurious ack during that first edge. d = ack delay in ACCESS cycles.
  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int d, input logic [DW-1:0] rdv,
                       input bit hold, input bit stray);
    exp_t e;
    req_t r;
    memread = rd; memwrite = wr; memaddress = a; memin = wd;
    if (stray) begin ext_ack = 1'b1; ext_rdata = $urandom; end
    if (rd && wr) begin
      e.is_err = 1'b1; e.accessed = 1'b0; e.run = 0; e.mem = drv_mem;
    end else begin
      r.addr = a; r.we = wr; r.wdata = wd;
      req_q.push_back(r);
      e.accessed = 1'b1;
      if (d < TO) begin
        e.is_err = 1'b0; e.run = d + 1;
        if (rd) drv_mem = rdv;
      end else begin
        e.is_err = 1'b1; e.run = TO;
      end
      e.mem = drv_mem;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    ext_ack = 1'b0;
    if (hold) begin @(posedge clk); #1; end
    memread = 1'b0; memwrite = 1'b0;
    if (!(rd && wr)) begin
      for (int i = 0; i < TO && i <= d; i++) begin
        if (i == d) begin ext_ack = 1'b1; ext_rdata = rdv; end
        else ext_rdata = $urandom;
        @(posedge clk); #1;
        ext_ack = 1'b0;
      end
    end
  endtask

  // Monitor: tracks the ext_req run length, checks each handshake's
  // attributes at its first cycle and each completion against the queue.
  logic [DW-1:0] model_mem = '0;
  bit   prev_req = 1'b0;
  int   run = 0, last_run = 0;
  exp_t em;
  req_t rm;
  always @(negedge clk) begin
    if (rst) begin
      model_mem = '0; prev_req = 1'b0; run = 0;
    end else begin
      if (ext_req) run++;
      else if (prev_req) begin last_run = run; run = 0; end
      if (ext_req && !prev_req) begin
        if (req_q.size() == 0) chk("unexpected_ext_req", 1, 0);
        else begin
          rm = req_q.pop_front();
          chk("ext_addr", ext_addr, rm.addr);
          chk("ext_we", ext_we, rm.we);
          chk("ext_wdata", ext_wdata, rm.wdata);
        end
      end
      chk("stall_vs_req", stall, ext_req);
      if (done || err) begin
        if (exp_q.size() == 0) chk("unexpected_done_err", {done, err}, 0);
        else begin
          em = exp_q.pop_front();
          chk("done_err_kind", {done, err}, em.is_err ? 2'b01 : 2'b10);
          chk("memout_at_end", memout, em.mem);
          model_mem = em.mem;
          if (em.accessed) chk("req_cycles", last_run, em.run);
        end
      end else begin
        chk("memout_hold", memout, model_mem);
      end
      prev_req = ext_req;
    end
  end

  initial begin
    bit last_done;
    int kind, d;
    rst = 1'b1; memaddress = '0; memin = '0; memread = 1'b0; memwrite = 1'b0;
    ext_rdata = '0; ext_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ext_req", ext_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_memout", memout, 0);
    chk("rst_ext_addr", ext_addr, 0);
    chk("rst_done_err", {done, err}, 0);
    @(posedge clk); #1;

    // Read acked in the third ACCESS cycle, then memout held while idle.
    issue(1, 0, 22'h12345, 32'h0, 2, 32'hDEADBEEF, 0, 0);
    repeat (11) @(posedge clk);
    #1;
    chk("memout_after_idle", memout, 32'hDEADBEEF);

    // Write to the top address, immediate ack.
    issue(0, 1, 22'h3FFFFF, 32'hA5A5A5A5, 0, 32'h11111111, 0, 0);
    @(posedge clk); #1;

    // Read never acked: abort after TO request cycles.
    issue(1, 0, 22'h00ABC, 32'h0, TO + 5, 32'h0, 0, 0);

    // Both strobes together.
    issue(1, 1, 22'h00001, 32'h5, 0, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back: read re-presented during done, with a late stray ack.
    issue(0, 1, 22'h00100, 32'hCAFEF00D, 1, 32'h0, 0, 0);
    issue(1, 0, 22'h00200, 32'h0, 2, 32'h600DD00D, 1, 1);
    @(posedge clk); #1;

    // Reset in the middle of an access.
    memread = 1'b1; memaddress = 22'h2AAAA;
    req_q.push_back('{addr: 22'h2AAAA, we: 1'b0, wdata: 32'h0});
    @(posedge clk); #1;
    memread = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; drv_mem = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ext_req", ext_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_memout", memout, 0);
    chk("midrst_done_err", {done, err}, 0);
    @(posedge clk); #1;

    // Randomized traffic.
    last_done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      d    = $urandom_range(0, TO + 1);
      if (last_done && $urandom_range(0, 1) == 1) begin
        issue(kind < 5, kind == 0 || kind >= 5, AW'($urandom), $urandom, d, $urandom,
              1, $urandom_range(0, 1) == 1);
      end else begin
        if (last_done) begin @(posedge clk); #1; end
        repeat ($urandom_range(0, 2)) begin
          ext_ack = $urandom_range(0, 1) == 1; ext_rdata = $urandom;
          @(posedge clk); #1;
          ext_ack = 1'b0;
        end
        issue(kind < 5, kind == 0 || kind >= 5, AW'($urandom), $urandom, d, $urandom, 0, 0);
      end
      last_done = (kind != 0) && (d < TO);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("req_q_drained", req_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
